// File: rtl/timer_display_pkg.sv
// Shared constants for the mm:ss display slice: field widths, digit slots,
// decoder codes and active-high segment patterns (bit 0 = a ... bit 6 = g).
package timer_pkg;

    localparam int unsigned SEC_W     = 7;
    localparam int unsigned MIN_W     = 4;
    localparam int unsigned SNAP_W    = MIN_W + SEC_W;
    localparam int unsigned COUNT_W   = 12;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned DIG_N     = 4;
    localparam int unsigned DIG_IDX_W = 2;
    localparam int unsigned CODE_W    = 4;

    localparam logic [DIG_IDX_W-1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [DIG_IDX_W-1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [DIG_IDX_W-1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [DIG_IDX_W-1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [SEC_W-1:0] SEC_MAX = 7'd59;

    localparam logic [CODE_W-1:0] CODE_DASH  = 4'd10;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd11;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Returns {tens, ones}; tens saturates harmlessly above 99 since such
    // values are shown as dashes anyway.
    function automatic logic [2*CODE_W-1:0] split_dec(input logic [SEC_W-1:0] v);
        return {CODE_W'(v / 7'd10), CODE_W'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/timer_display_if.sv
// Display-side bundle: packed timer word and hold in, digit/segment drive out.
interface timer_display_if;
    import timer_pkg::*;

    logic [COUNT_W-1:0] count;
    logic               hold;
    logic [DIG_N-1:0]   an;
    logic [SEG_W-1:0]   seg;
    logic               dp;
    logic               err;

    modport master (
        output count,
        output hold,
        input  an,
        input  seg,
        input  dp,
        input  err
    );

    modport slave (
        input  count,
        input  hold,
        output an,
        output seg,
        output dp,
        output err
    );

endinterface

// File: rtl/timer_display_seg7_decode.sv
// Digit code to active-high a..g pattern; 10 = dash, 11 and above = blank.
module seg7_decode
    import timer_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/timer_display.sv
// Four-digit multiplexed mm:ss display driver with a once-per-scan snapshot
// of the timer word, leading-zero blanking and out-of-range seconds flag.
module timer_display
    import timer_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEAD     = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    timer_display_if.slave bus
);

    localparam int unsigned          PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [DIG_N-1:0]     AN_OFF     = {DIG_N{SEG_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]     SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};

    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DIG_IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [SNAP_W-1:0]    snap_q, snap_d;
    logic                 tc;

    logic [MIN_W-1:0]     min_val;
    logic [SEC_W-1:0]     sec_val;
    logic [2*CODE_W-1:0]  min_dec, sec_dec;
    logic                 sec_err;
    logic [CODE_W-1:0]    code;
    logic [SEG_W-1:0]     pattern;
    logic [DIG_N-1:0]     an_act;

    logic [DIG_N-1:0]     an_q, an_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 err_q, err_d;

    logic                 unused_count_msb;
    assign unused_count_msb = bus.count[COUNT_W-1];

    always_comb begin
        tc          = (presc_q == PRESC_LAST);
        presc_d     = tc ? '0 : presc_q + PRESC_W'(1);
        digit_idx_d = tc ? digit_idx_q + DIG_IDX_W'(1) : digit_idx_q;
        snap_d      = snap_q;
        // Load only at the end of the last slot so a whole scan shows one value.
        if (tc && (digit_idx_q == DIG_MIN_TENS) && !bus.hold) begin
            snap_d = bus.count[SNAP_W-1:0];
        end
    end

    assign min_val = snap_q[SNAP_W-1:SEC_W];
    assign sec_val = snap_q[SEC_W-1:0];
    assign min_dec = split_dec(SEC_W'(min_val));
    assign sec_dec = split_dec(sec_val);
    assign sec_err = (sec_val > SEC_MAX);

    always_comb begin
        code = CODE_BLANK;
        case (digit_idx_q)
            DIG_SEC_ONES: code = sec_err ? CODE_DASH : sec_dec[CODE_W-1:0];
            DIG_SEC_TENS: code = sec_err ? CODE_DASH : sec_dec[2*CODE_W-1:CODE_W];
            DIG_MIN_ONES: code = min_dec[CODE_W-1:0];
            DIG_MIN_TENS: begin
                if (BLANK_LEAD && (min_dec[2*CODE_W-1:CODE_W] == '0)) begin
                    code = CODE_BLANK;
                end else begin
                    code = min_dec[2*CODE_W-1:CODE_W];
                end
            end
            default:      code = CODE_BLANK;
        endcase
    end

    seg7_decode u_seg7_decode (
        .code (code),
        .seg  (pattern)
    );

    // Everything is active-high up to here; XOR with the off pattern applies
    // the pad polarity in one place.
    always_comb begin
        an_act = DIG_N'(1) << digit_idx_q;
        an_d   = an_act ^ AN_OFF;
        seg_d  = pattern ^ SEG_OFF;
        dp_d   = (digit_idx_q == DIG_MIN_ONES) ^ SEG_ACTIVE_LOW;
        err_d  = sec_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            digit_idx_q <= DIG_SEC_ONES;
            snap_q      <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
            err_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            digit_idx_q <= digit_idx_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            err_q       <= err_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.err = err_q;

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
- Downstream consumer of the mm:ss timer word. Drives a 4-digit multiplexed 7-segment display.
- Takes the 12-bit packed count {min[3:0], sec[6:0]}, snapshots it once per full scan to avoid tearing, converts each field to two decimal digits and scans the digits.
- Minutes and seconds are separated by a lit decimal point acting as the colon.
- Also flags out-of-range seconds.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays active. Minimum 2.
- SEG_ACTIVE_LOW, 1: 1 means an/seg/dp are active-low; 0 means active-high.
- BLANK_LEAD, 1: 1 blanks the minute-tens digit when it is 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- count  in  12  {min[11:7] unused… see below}. Bits [11:7] are minutes (only [10:7] significant, 4 bits); bits [6:0] are seconds (0..59 valid).
- hold  in  1  1 = freeze the displayed value (snapshot not updated).
- an  out  4  digit enables. an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, lit only on digit 2 (the colon).
- err  out  1  1 while the snapshot holds seconds > 59.

Behaviour:
- Field mapping: min = count[10:7] (0..15), sec = count[6:0]. Bit 11 is ignored.
- Reset (rst=0, async):
  - Prescaler = 0, digit_idx = 0, snapshot = 0.
  - Outputs inactive: an, seg and dp all off (all 1 when SEG_ACTIVE_LOW), err = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. Its terminal count (tc) advances digit_idx 0→1→2→3→0.
- Snapshot:
  - Loaded from count on the cycle where tc=1, digit_idx=3 and hold=0. New value is visible from digit 0 onward.
  - hold=1 retains the snapshot indefinitely; scanning continues.
  - Changes to count mid-scan have no effect until the next load.
- Digit values from the snapshot:
  - min tens = min/10 (0 or 1); min ones = min%10.
  - sec tens = sec/10; sec ones = sec%10.
  - Division is combinational on the narrow fields.
- Output registers:
  - an, seg, dp and err are registered from digit_idx and snapshot, so they lag digit_idx by 1 cycle.
  - First edge after reset release shows digit 0 of snapshot 0: an=1110, seg='0'.
- Exactly one an bit is active at any time after the first post-reset edge.
- Seconds > 59 (60..127): err=1, and both seconds digits show a dash (segment g only). Minute digits are still shown normally.
- Leading blank: with BLANK_LEAD=1 and min tens = 0, an[3] is still active for its slot but seg is all off. dp rules are unaffected.
- Polarity: all logic is computed active-high and inverted at the output registers when SEG_ACTIVE_LOW=1.
- Reset mid-scan: immediately returns to reset values. Scan restarts at digit 0 with snapshot 0.

Decomposition:
- Shared package (timer_pkg):
  - Segment pattern constants for 0-9, dash and blank (active-high, a..g).
  - Digit index constants DIG_SEC_ONES=0 … DIG_MIN_TENS=3.
  - Field width constants SEC_W=7, MIN_W=4.
- One sub-module: seg7_decode, combinational 4-bit code → 7-bit active-high pattern, with codes 10 = dash and 11 = blank.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1, BLANK_LEAD=1; patterns below are active-low, bit order g..a):
1. Reset:
   - Assert rst=0 → an=1111, seg=1111111, dp=1, err=0.
   - Release rst → next edge an=1110, seg=1000000 ('0').
   - an then advances every 4 cycles.
2. Normal value:
   - count = {1'b0, 4'd12, 7'd34}; wait one full scan (16 cycles) past a load.
   - Digit 3 shows 1 (1111001), digit 2 shows 2 (0100100) with dp=0, digit 1 shows 3 (0110000), digit 0 shows 4 (0011001).
3. Tear-free update:
   - Change count to 05:09 while digit 1 is active.
   - Digits 1 and 0 still show 3 and 4.
   - New value appears starting at the next digit-0 slot.
4. Hold:
   - hold=1, then count changes repeatedly over 64 cycles → display stays at the old value.
   - hold=0 → new value appears after the next digit-3→0 transition.
5. Out of range:
   - count sec=60, min=0 → err=1.
   - Digits 1 and 0 show 0111111 (dash); digit 3 blank (1111111); digit 2 shows '0'.
   - Returning sec to 59 clears err after the next load.
6. Mid-scan reset: pulse rst low during digit 2 → outputs are off asynchronously, then the scan resumes at digit 0 showing 0.
